// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential imem requests, in-order response FIFO, {pc, insn} to decode.
// Latency: response pushed at the end of its resp_vld_i cycle, visible on vld_o the next cycle.
// Backpressure: requests are credit-limited so that queued + outstanding + stale never exceeds DEPTH.

// Small circular FIFO with synchronous flush.
// Latency: push visible at the head one cycle later; no bypass.
// Backpressure: none internally; the caller guarantees no push when full without a pop.
module fetch_queue_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    // Storage needs no reset: the head is only observed while cnt is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_queue #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [AWIDTH-1:0] BOOT_ADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] req_addr_o,
    output logic              req_vld_o,
    input  logic              req_rdy_i,
    input  logic [DWIDTH-1:0] resp_data_i,
    input  logic              resp_vld_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              err_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
    } entry_t;

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] resp_pc;
    logic [AWIDTH-1:0] restart_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     occ;
    logic              credit_ok;
    logic              req_fire;
    logic              resp_take;
    logic              resp_drop;
    logic              resp_stray;
    logic              full;
    logic              push;
    logic              pop;
    logic              overflow;
    entry_t            push_dat;
    entry_t            head_dat;

    // Every request reserves a FIFO slot until its response is pushed or discarded.
    assign credit_ok  = (SW'(occ) + SW'(outstanding) + SW'(drop)) < SW'(DEPTH);
    assign req_vld_o  = rst && !redirect_i && credit_ok;
    assign req_addr_o = fetch_pc;
    assign req_fire   = req_vld_o && req_rdy_i;

    assign resp_drop  = resp_vld_i && (drop != '0);
    assign resp_take  = resp_vld_i && (drop == '0) && (outstanding != '0);
    assign resp_stray = resp_vld_i && (drop == '0) && (outstanding == '0);

    assign full     = (occ == CW'(DEPTH));
    assign pop      = vld_o && rdy_i && !redirect_i;
    assign push     = resp_take && !redirect_i && (!full || pop);
    assign overflow = resp_take && !redirect_i && full && !pop;

    assign restart_pc = redirect_pc_i & ~AWIDTH'(3);
    assign push_dat   = '{pc: resp_pc, insn: resp_data_i};

    fetch_queue_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .cnt      (occ)
    );

    assign vld_o  = (occ != '0);
    assign pc_o   = vld_o ? head_dat.pc   : '0;
    assign insn_o = vld_o ? head_dat.insn : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            outstanding <= '0;
            drop        <= '0;
            err_o       <= 1'b0;
        end else begin
            if (resp_stray || overflow) err_o <= 1'b1;
            if (redirect_i) begin
                // In-flight requests become stale; a response arriving now is already one of them.
                fetch_pc    <= restart_pc;
                resp_pc     <= restart_pc;
                drop        <= drop + outstanding - CW'(resp_drop || resp_take);
                outstanding <= '0;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + AWIDTH'(4);
                if (resp_take) resp_pc  <= resp_pc + AWIDTH'(4);
                if (resp_drop) drop     <= drop - CW'(1);
                outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner-case sequences, random run vs model.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] B     = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr_o;
    logic        req_vld_o;
    logic        req_rdy_i = 1'b0;
    logic [31:0] resp_data_i = '0;
    logic        resp_vld_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic        vld_o;
    logic        rdy_i = 1'b0;
    logic        err_o;

    always #5 clk = ~clk;

    fetch_queue #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .DEPTH     (DEPTH),
        .BOOT_ADDR (B)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_addr_o    (req_addr_o),
        .req_vld_o     (req_vld_o),
        .req_rdy_i     (req_rdy_i),
        .resp_data_i   (resp_data_i),
        .resp_vld_i    (resp_vld_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .insn_o        (insn_o),
        .vld_o         (vld_o),
        .rdy_i         (rdy_i),
        .err_o         (err_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        bit          rst_before;
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    // imem_q: every accepted request not yet answered; mq: what decode should see, head first.
    req_t        imem_q[$];
    logic [31:0] mq[$];
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_fetch_pc = B;
    bit          model_chk = 1'b0;
    bit          inj_resp = 1'b0;

    logic        s_req, s_vld, s_err;
    logic [31:0] s_addr, s_pc, s_insn;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input bit chk);
        #2 rst = 1'b0;
        resp_vld_i = 1'b0;
        redirect_i = 1'b0;
        inj_resp   = 1'b0;
        #1;
        if (chk) begin
            check("rst_vld",     32'(vld_o),     32'd0);
            check("rst_req_vld", 32'(req_vld_o), 32'd0);
            check("rst_pc",      pc_o,           32'd0);
            check("rst_insn",    insn_o,         32'd0);
            check("rst_err",     32'(err_o),     32'd0);
        end
        imem_q.delete();
        mq.delete();
        m_fetch_pc = B;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock: drive imem response, sample at negedge, advance imem and model at posedge.
    task automatic cycle(input vec_t v, input bit use_v);
        req_t r;
        req_t n;
        bit   resp, fire, pop, exp_req;
        resp = (imem_q.size() > 0) && (imem_q[0].due <= cyc);
        resp_vld_i  = resp || inj_resp;
        resp_data_i = resp ? insn_of(imem_q[0].addr) : 32'h0;
        @(negedge clk);
        s_req = req_vld_o; s_addr = req_addr_o; s_vld = vld_o;
        s_pc = pc_o; s_insn = insn_o; s_err = err_o;
        if (use_v) begin
            check("tbl_req_vld", 32'(s_req), 32'(v.exp_req));
            if (v.exp_req) check("tbl_req_addr", s_addr, v.exp_addr);
            check("tbl_vld",  32'(s_vld), 32'(v.exp_vld));
            check("tbl_pc",   s_pc, v.exp_pc);
            check("tbl_insn", s_insn, v.exp_vld ? insn_of(v.exp_pc) : 32'h0);
        end
        if (model_chk) begin
            exp_req = !redirect_i && (mq.size() + imem_q.size() < DEPTH);
            check("rnd_req_vld", 32'(s_req), 32'(exp_req));
            if (exp_req) check("rnd_req_addr", s_addr, m_fetch_pc);
            check("rnd_vld",  32'(s_vld), 32'(mq.size() != 0));
            check("rnd_pc",   s_pc,   (mq.size() != 0) ? mq[0] : 32'h0);
            check("rnd_insn", s_insn, (mq.size() != 0) ? insn_of(mq[0]) : 32'h0);
            check("rnd_err",  32'(s_err), 32'd0);
        end
        fire = s_req && req_rdy_i;
        pop  = s_vld && rdy_i;
        @(posedge clk);
        if (resp) r = imem_q.pop_front();
        if (fire) begin
            n.addr = s_addr; n.due = cyc + lat; n.epoch = epoch;
            imem_q.push_back(n);
        end
        if (redirect_i) begin
            mq.delete();
            epoch++;
            m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (resp && r.epoch == epoch) mq.push_back(r.addr);
            if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
        #1;
    endtask

    initial begin
        vec_t tbl[16];
        vec_t nov;
        int   fires;
        bit   found;

        nov = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        // Rows 0-4: 1-cycle imem, decode always ready. Rows 5-15: decode stalled, then drains.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, B,          1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, B + 32'h04, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, B + 32'h08, 1'b1, B};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, B + 32'h0C, 1'b1, B + 32'h04};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, B + 32'h10, 1'b1, B + 32'h08};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, B,          1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, B + 32'h04, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, B + 32'h08, 1'b1, B};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, B + 32'h0C, 1'b1, B};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, B};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, B};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, B};
        tbl[12] = '{1'b0, 1'b1, 1'b1, B + 32'h10, 1'b1, B + 32'h04};
        tbl[13] = '{1'b0, 1'b1, 1'b1, B + 32'h14, 1'b1, B + 32'h08};
        tbl[14] = '{1'b0, 1'b1, 1'b1, B + 32'h18, 1'b1, B + 32'h0C};
        tbl[15] = '{1'b0, 1'b1, 1'b1, B + 32'h1C, 1'b1, B + 32'h10};

        @(posedge clk);
        #1;
        do_reset(1'b1);

        lat = 1;
        req_rdy_i = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset(1'b0);
            rdy_i = tbl[i].rdy;
            cycle(tbl[i], 1'b1);
        end

        // Redirect with two requests in flight on a 3-cycle imem.
        do_reset(1'b0);
        lat = 3; rdy_i = 1'b1; req_rdy_i = 1'b1;
        cycle(nov, 1'b0);
        cycle(nov, 1'b0);
        req_rdy_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = B + 32'h42;
        cycle(nov, 1'b0);
        check("redir_no_req", 32'(s_req), 32'd0);
        redirect_i = 1'b0; req_rdy_i = 1'b1; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(nov, 1'b0);
            if (s_vld) begin
                found = 1'b1;
                check("redir_pc",   s_pc,   B + 32'h40);
                check("redir_insn", s_insn, insn_of(B + 32'h40));
            end
        end
        check("redir_vld_seen", 32'(found), 32'd1);

        // imem stalls requests; address holds and no credit is consumed.
        do_reset(1'b0);
        lat = 1; rdy_i = 1'b0; req_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(nov, 1'b0);
            check("stall_req_vld", 32'(s_req), 32'd1);
            check("stall_addr",    s_addr,     B);
            check("stall_vld",     32'(s_vld), 32'd0);
        end
        req_rdy_i = 1'b1; fires = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(nov, 1'b0);
            if (s_req) fires++;
        end
        check("stall_credit", 32'(fires), 32'(DEPTH));
        check("stall_head",   s_pc,       B);

        // Asynchronous reset in the middle of streaming.
        do_reset(1'b0);
        lat = 2; rdy_i = 1'b1; req_rdy_i = 1'b1;
        repeat (6) cycle(nov, 1'b0);
        check("mid_vld_before", 32'(s_vld), 32'd1);
        do_reset(1'b1);
        cycle(nov, 1'b0);
        check("post_rst_req",  32'(s_req), 32'd1);
        check("post_rst_addr", s_addr,     B);
        check("post_rst_vld",  32'(s_vld), 32'd0);

        // Unsolicited response while the FIFO is full.
        do_reset(1'b0);
        lat = 1; rdy_i = 1'b0; req_rdy_i = 1'b1;
        repeat (8) cycle(nov, 1'b0);
        inj_resp = 1'b1;
        cycle(nov, 1'b0);
        inj_resp = 1'b0;
        check("stray_err_before", 32'(s_err), 32'd0);
        cycle(nov, 1'b0);
        check("stray_err",  32'(s_err), 32'd1);
        check("stray_vld",  32'(s_vld), 32'd1);
        check("stray_head", s_pc,       B);
        repeat (3) cycle(nov, 1'b0);
        check("stray_err_sticky", 32'(s_err), 32'd1);
        rdy_i = 1'b1; req_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(nov, 1'b0);
            check("stray_drain", s_pc, B + 32'(4 * i));
        end
        cycle(nov, 1'b0);
        check("stray_empty", 32'(s_vld), 32'd0);

        // Random traffic against the reference model.
        do_reset(1'b1);
        model_chk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            rdy_i         = ($urandom_range(0, 9) < 7);
            req_rdy_i     = ($urandom_range(0, 9) < 8);
            redirect_i    = ($urandom_range(0, 24) == 0);
            redirect_pc_i = $urandom;
            cycle(nov, 1'b0);
        end
        model_chk  = 1'b0;
        redirect_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
